// File: rtl/fpga_logic_cell.sv
// fpga_logic_cell: LUT + optional DFF logic element with serial config load; LC_CFG_READBACK_EN adds the cfg_bit_o daisy-chain output
module fpga_logic_cell #(
    parameter int LUT_K = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cfg_valid_i,
    input  logic             cfg_bit_i,
    output logic             cfg_ready_o,
    output logic             cfg_done_o,
    input  logic             cfg_clear_i,
    input  logic [LUT_K-1:0] in_i,
    input  logic             fcin_i,
    input  logic             ce_i,
    input  logic             sr_i,
    output logic             lut_o,
    output logic             o_o
`ifdef LC_CFG_READBACK_EN
    ,
    output logic             cfg_bit_o
`endif
);
    localparam int N = 2**LUT_K;
    localparam int CFG_W = N + 3;
    localparam int CW = $clog2(CFG_W);
    typedef enum logic {LOAD, ACTIVE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic q_q, q_d;
    logic accept, last;
    logic [LUT_K-1:0] idx;
    // A clear in the same cycle as an offered bit restarts the load without consuming that bit
    always_comb begin
        accept = cfg_valid_i && state_q == LOAD && !cfg_clear_i;
        last = cnt_q == CW'(CFG_W - 1);
        idx = {cfg_q[N] ? fcin_i : in_i[LUT_K-1], in_i[LUT_K-2:0]};
        lut_o = state_q == ACTIVE && cfg_q[idx];
        state_d = cfg_clear_i ? LOAD : (accept && last) ? ACTIVE : state_q;
        cnt_d = cfg_clear_i ? '0 : (accept && !last) ? cnt_q + 1'b1 : cnt_q;
        cfg_d = accept ? {cfg_bit_i, cfg_q[CFG_W-1:1]} : cfg_q;
        q_d = (state_q != ACTIVE || cfg_clear_i) ? 1'b0 : sr_i ? cfg_q[N+2] : ce_i ? lut_o : q_q;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= LOAD;
            cnt_q <= '0;
            cfg_q <= '0;
            q_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            cfg_q <= cfg_d;
            q_q <= q_d;
        end
    end
`ifdef LC_CFG_READBACK_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) cfg_bit_o <= 1'b0;
        else if (accept) cfg_bit_o <= cfg_q[0];
    end
`endif
    assign cfg_ready_o = state_q == LOAD;
    assign cfg_done_o = state_q == ACTIVE;
    assign o_o = cfg_q[N+1] ? q_q : lut_o;
endmodule

// File: tb/tb_fpga_logic_cell.sv
// tb_fpga_logic_cell: directed scoreboard bench; stimulus queues expectations, a negedge monitor checks them
module tb_fpga_logic_cell;
  logic clk = 1'b0;
  logic reset_i, cfg_valid_i, cfg_bit_i, cfg_clear_i, fcin_i, ce_i, sr_i;
  logic [3:0] in_i;
  logic cfg_ready_o, cfg_done_o, lut_o, o_o;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string name;
    int sel;
    logic exp;
  } exp_t;
  exp_t sbq[$];
  always #5 clk = ~clk;
`ifdef LC_CFG_READBACK_EN
  logic cfg_bit_o, v2, chain_en, ready2, done2, lut2, o2;
  always @(posedge clk) v2 <= chain_en && cfg_valid_i && cfg_ready_o;
  fpga_logic_cell dut2 (
    .clk_i(clk), .reset_i(reset_i), .cfg_valid_i(v2), .cfg_bit_i(cfg_bit_o),
    .cfg_ready_o(ready2), .cfg_done_o(done2), .cfg_clear_i(1'b0), .in_i(in_i),
    .fcin_i(fcin_i), .ce_i(ce_i), .sr_i(sr_i), .lut_o(lut2), .o_o(o2), .cfg_bit_o()
  );
`endif
  fpga_logic_cell dut (
    .clk_i(clk), .reset_i(reset_i), .cfg_valid_i(cfg_valid_i), .cfg_bit_i(cfg_bit_i),
    .cfg_ready_o(cfg_ready_o), .cfg_done_o(cfg_done_o), .cfg_clear_i(cfg_clear_i),
    .in_i(in_i), .fcin_i(fcin_i), .ce_i(ce_i), .sr_i(sr_i), .lut_o(lut_o), .o_o(o_o)
`ifdef LC_CFG_READBACK_EN
    , .cfg_bit_o(cfg_bit_o)
`endif
  );
  function automatic logic pick(int sel);
    case (sel)
      0: return cfg_ready_o;
      1: return cfg_done_o;
      2: return lut_o;
`ifdef LC_CFG_READBACK_EN
      4: return cfg_bit_o;
      5: return lut2;
      6: return done2;
`endif
      default: return o_o;
    endcase
  endfunction
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t e;
      logic act;
      e = sbq.pop_front();
      act = pick(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%b required=%b", e.name, act, e.exp);
      end
    end
  end
  task automatic expect_v(input string name, input int sel, input logic v);
    exp_t e;
    e.name = name;
    e.sel = sel;
    e.exp = v;
    sbq.push_back(e);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    cfg_valid_i = 1'b1;
    cfg_bit_i = b;
    step();
    cfg_valid_i = 1'b0;
  endtask
  task automatic load_bits(input logic [18:0] w, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap) step();
      send_bit(w[i]);
    end
  endtask
  task automatic clear_pulse();
    cfg_clear_i = 1'b1;
    step();
    cfg_clear_i = 1'b0;
  endtask
  task automatic set_in(input logic [3:0] v, input logic f);
    in_i = v;
    fcin_i = f;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [18:0] w;
    reset_i = 1'b1;
    {cfg_valid_i, cfg_bit_i, cfg_clear_i, fcin_i, ce_i, sr_i} = '0;
    in_i = 4'hF;
`ifdef LC_CFG_READBACK_EN
    chain_en = 1'b0;
`endif
    step();
    step();
    checks += 4;
    if (cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready actual=%b required=1", cfg_ready_o);
    end
    if (cfg_done_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_done actual=%b required=0", cfg_done_o);
    end
    if (lut_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_lut actual=%b required=0", lut_o);
    end
    if (o_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_o actual=%b required=0", o_o);
    end
    reset_i = 1'b0;
    w = {3'b000, 16'h8000};
    load_bits(w, 18, 0);
    expect_v("t1_ready_18", 0, 1'b1);
    expect_v("t1_done_18", 1, 1'b0);
    expect_v("t1_lut_gated", 2, 1'b0);
    send_bit(w[18]);
    expect_v("t1_done_19", 1, 1'b1);
    expect_v("t1_ready_19", 0, 1'b0);
    expect_v("t1_o_F", 3, 1'b1);
    step();
    set_in(4'hE, 1'b0);
    expect_v("t1_o_E", 3, 1'b0);
    step();
    clear_pulse();
    expect_v("t2_ready_clr", 0, 1'b1);
    load_bits({3'b001, 16'hFF00}, 19, 0);
    for (int i = 0; i < 4; i++) begin
      set_in({i[1], 3'(3 * i + 1)}, i[0]);
      expect_v($sformatf("t2_fcin_%0d", i), 3, i[0]);
      step();
    end
    clear_pulse();
    ce_i = 1'b1;
    set_in(4'h0, 1'b0);
    load_bits({3'b010, 16'hFFFF}, 19, 0);
    expect_v("t3_done", 1, 1'b1);
    expect_v("t3_q_not_loaded", 3, 1'b0);
    expect_v("t3_lut", 2, 1'b1);
    step();
    expect_v("t3_q_ce", 3, 1'b1);
    sr_i = 1'b1;
    step();
    expect_v("t3_q_sr", 3, 1'b0);
    sr_i = 1'b0;
    ce_i = 1'b0;
    step();
    expect_v("t3_q_hold0", 3, 1'b0);
    ce_i = 1'b1;
    step();
    expect_v("t3_q_ce2", 3, 1'b1);
    ce_i = 1'b0;
    step();
    step();
    expect_v("t3_q_hold1", 3, 1'b1);
    clear_pulse();
    expect_v("t5_ready", 0, 1'b1);
    expect_v("t5_done", 1, 1'b0);
    expect_v("t5_lut", 2, 1'b0);
    expect_v("t5_o", 3, 1'b0);
    load_bits({3'b000, 16'h0001}, 19, 0);
    expect_v("t5_new_i0", 3, 1'b1);
    step();
    set_in(4'h1, 1'b0);
    expect_v("t5_new_i1", 3, 1'b0);
    clear_pulse();
    w = {3'b000, 16'h6996};
    load_bits(w, 7, 0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    expect_v("t5_rst_ready", 0, 1'b1);
    load_bits(w, 18, 0);
    expect_v("t5_rst_count18", 0, 1'b1);
    send_bit(w[18]);
    expect_v("t5_rst_done", 1, 1'b1);
    set_in(4'h3, 1'b0);
    expect_v("t5_xor_3", 2, 1'b0);
    step();
    set_in(4'h7, 1'b0);
    expect_v("t5_xor_7", 2, 1'b1);
    step();
    clear_pulse();
    w = {3'b000, 16'h00F0};
    load_bits(w, 10, 2);
    step();
    expect_v("t4_ready_gap", 0, 1'b1);
    load_bits(w >> 10, 9, 2);
    expect_v("t4_done", 1, 1'b1);
    load_bits(19'h7FFFF, 5, 0);
    expect_v("t4_ready_after", 0, 1'b0);
    set_in(4'h4, 1'b0);
    expect_v("t4_lut_4", 2, 1'b1);
    step();
    set_in(4'h0, 1'b0);
    expect_v("t4_lut_0", 2, 1'b0);
    step();
    set_in(4'h8, 1'b0);
    expect_v("t4_lut_8", 2, 1'b0);
    step();
`ifdef LC_CFG_READBACK_EN
    clear_pulse();
    w = {3'b000, 16'hA5C3};
    load_bits(w, 19, 0);
    clear_pulse();
    for (int i = 0; i < 19; i++) begin
      send_bit(i[0]);
      expect_v($sformatf("t6_rb_%0d", i), 4, w[i]);
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    load_bits({3'b000, 16'h8000}, 19, 0);
    clear_pulse();
    chain_en = 1'b1;
    load_bits({3'b000, 16'h0001}, 19, 0);
    step();
    chain_en = 1'b0;
    expect_v("t6_chain_done2", 6, 1'b1);
    set_in(4'hF, 1'b0);
    expect_v("t6_chain_lut2_F", 5, 1'b1);
    expect_v("t6_chain_lut1_F", 2, 1'b0);
    step();
    set_in(4'h0, 1'b0);
    expect_v("t6_chain_lut2_0", 5, 1'b0);
    expect_v("t6_chain_lut1_0", 2, 1'b1);
    step();
`endif
    step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
